// File: rtl/transpose16_pkg.sv
// Shared constants and types for the 16x16 ping-pong transpose buffer.
package transpose16_pkg;
  localparam int N = 16;
  localparam logic [3:0] LAST_IDX = 4'(N - 1);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;

  // Bit offset of element idx inside a packed vector of width-sized elements.
  function automatic int elem_lsb(input int idx, input int width);
    return idx * width;
  endfunction
endpackage

// File: rtl/round_sat.sv
// Rounding arithmetic right shift followed by signed saturation; purely combinational.
module round_sat #(
  parameter int WIDTH_IN  = 20,
  parameter int WIDTH_OUT = 16,
  parameter int SHIFT     = 3
) (
  input  logic signed [WIDTH_IN-1:0]  din,
  output logic signed [WIDTH_OUT-1:0] dout
);
  // One guard bit so the rounding add cannot overflow.
  localparam int WE = WIDTH_IN + 1;
  localparam longint MAXL = (64'sd1 <<< (WIDTH_OUT - 1)) - 64'sd1;
  localparam logic signed [WE-1:0] MAXV = WE'(MAXL);
  localparam logic signed [WE-1:0] MINV = WE'(-MAXL - 64'sd1);

  logic signed [WE-1:0] ext;
  logic signed [WE-1:0] shifted;

  assign ext = {din[WIDTH_IN-1], din};

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [WE-1:0] RND = WE'(1) << (SHIFT - 1);
      logic signed [WE-1:0] biased;
      assign biased  = ext + RND;
      assign shifted = biased >>> SHIFT;
    end else begin : g_pass
      assign shifted = ext;
    end
  endgenerate

  always_comb begin
    dout = shifted[WIDTH_OUT-1:0];
    if (shifted > MAXV)      dout = MAXV[WIDTH_OUT-1:0];
    else if (shifted < MINV) dout = MINV[WIDTH_OUT-1:0];
  end
endmodule

// File: rtl/transpose16.sv
// Ping-pong 16x16 transpose: rows in (rounded and saturated on write), columns out.
// Column 0 appears one edge after row 15 is accepted; out_ready low stalls the reader.
module transpose16 import transpose16_pkg::*; #(
  parameter int WIDTH_IN  = 20,
  parameter int WIDTH_OUT = 16,
  parameter int SHIFT     = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N*WIDTH_IN-1:0]     in_row,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N*WIDTH_OUT-1:0]    out_col,
  output logic                      out_last
);
  logic [WIDTH_OUT-1:0] mem [2][N][N];
  logic [WIDTH_OUT-1:0] rnd [N];
  bank_state_t          state [2];
  logic                 wr_bank, rd_bank;
  logic [3:0]           wr_row, rd_col;
  logic                 wr_fire, rd_avail, rd_load;
  logic [N*WIDTH_OUT-1:0] rd_data;

  generate
    for (genvar c = 0; c < N; c++) begin : g_rs
      round_sat #(
        .WIDTH_IN (WIDTH_IN),
        .WIDTH_OUT(WIDTH_OUT),
        .SHIFT    (SHIFT)
      ) u_rs (
        .din (in_row[elem_lsb(c, WIDTH_IN) +: WIDTH_IN]),
        .dout(rnd[c])
      );
    end
  endgenerate

  assign in_ready = (state[wr_bank] == EMPTY) || (state[wr_bank] == FILLING);
  assign wr_fire  = in_valid && in_ready;
  assign rd_avail = (state[rd_bank] == FULL) || (state[rd_bank] == DRAINING);
  assign rd_load  = rd_avail && (!out_valid || out_ready);

  always_comb begin
    rd_data = '0;
    for (int r = 0; r < N; r++) begin
      rd_data[elem_lsb(r, WIDTH_OUT) +: WIDTH_OUT] = mem[rd_bank][r][rd_col];
    end
  end

  // Bank storage carries no reset; bank state gates every read.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int c = 0; c < N; c++) begin
        mem[wr_bank][wr_row][c] <= rnd[c];
      end
    end
  end

  // Writer and reader always own different banks, so their state updates never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state[0]  <= EMPTY;
      state[1]  <= EMPTY;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_row    <= 4'd0;
      rd_col    <= 4'd0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_col   <= '0;
    end else begin
      if (wr_fire) begin
        wr_row <= wr_row + 4'd1;
        if (wr_row == LAST_IDX) begin
          state[wr_bank] <= FULL;
          wr_bank        <= ~wr_bank;
        end else begin
          state[wr_bank] <= FILLING;
        end
      end

      if (rd_load) begin
        out_col   <= rd_data;
        out_valid <= 1'b1;
        out_last  <= (rd_col == LAST_IDX);
        rd_col    <= rd_col + 4'd1;
        if (rd_col == LAST_IDX) begin
          state[rd_bank] <= EMPTY;
          rd_bank        <= ~rd_bank;
        end else begin
          state[rd_bank] <= DRAINING;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_transpose16.sv
// Scoreboard bench for transpose16: directed blocks in, monitor checks every column out.
module tb_transpose16;
  localparam int WI = 20;
  localparam int WO = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [16*WI-1:0] in_row = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [16*WO-1:0] out_col;
  logic            out_last;

  transpose16 dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_row   (in_row),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_col  (out_col),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [16*WO-1:0] col;
    logic             last;
  } exp_t;

  exp_t exp_q[$];
  int   pop_cyc_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   stall_cnt = 0;
  int   in_m [16][16];
  int   exp_m[16][16];
  int   rnd_in [6] = '{3, 4, -5, -4, 524287, -524288};
  int   rnd_exp[6] = '{0, 1, -1, 0, 32767, -32768};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [16*WO-1:0] act, input logic [16*WO-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic abort(input string name);
    n_err++;
    $display("FAIL %s: timed out waiting on DUT", name);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $fatal(1, "timeout");
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_col: got %h expected no column", out_col);
      end else begin
        e = exp_q.pop_front();
        check("col", out_col, e.col);
        check("last", {255'd0, out_last}, {255'd0, e.last});
      end
      pop_cyc_q.push_back(cyc);
    end
  end

  function automatic logic [16*WI-1:0] pack_row(input int r);
    logic [16*WI-1:0] v;
    v = '0;
    for (int c = 0; c < 16; c++) v[c*WI +: WI] = WI'(in_m[r][c]);
    return v;
  endfunction

  task automatic push_block();
    exp_t e;
    for (int c = 0; c < 16; c++) begin
      e.col = '0;
      for (int r = 0; r < 16; r++) e.col[r*WO +: WO] = WO'(exp_m[r][c]);
      e.last = (c == 15);
      exp_q.push_back(e);
    end
  endtask

  task automatic fill_plain();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        in_m[r][c]  = 8 * (16*r + c);
        exp_m[r][c] = 16*r + c;
      end
  endtask

  // Inputs 8v+k with k in 0..3 all round to v at SHIFT=3.
  task automatic fill_pat(input int blk);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        exp_m[r][c] = blk*256 + 16*r + c - 2000;
        in_m[r][c]  = 8 * exp_m[r][c] + ((r + c) % 4);
      end
  endtask

  task automatic send_rows(input int n);
    int   guard;
    logic acc;
    for (int r = 0; r < n; r++) begin
      in_row   = pack_row(r);
      in_valid = 1'b1;
      acc      = 1'b0;
      guard    = 0;
      while (!acc) begin
        @(negedge clk);
        acc = in_ready;
        if (!acc) stall_cnt++;
        @(posedge clk);
        #1;
        guard++;
        if (!acc && guard > 300) abort("send_row");
      end
      if (r == 15) push_block();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 1000) begin
      @(posedge clk);
      guard++;
    end
    repeat (20) @(posedge clk);
    #1;
    check(name, 256'(exp_q.size()), 256'd0);
  endtask

  initial begin
    int   base;
    int   acc_cnt;
    int   cur_blk;
    logic a;
    logic prev_rdy;
    logic seen;

    // Reset state.
    #2 rst = 1'b1;
    #1;
    check("rst_in_ready", {255'd0, in_ready}, 256'd1);
    check("rst_out_valid", {255'd0, out_valid}, 256'd0);
    check("rst_out_last", {255'd0, out_last}, 256'd0);
    check("rst_out_col", out_col, 256'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Transpose exactness and first-column latency.
    out_ready = 1'b1;
    fill_plain();
    send_rows(16);
    @(negedge clk);
    check("lat_edge_k", {255'd0, out_valid}, 256'd0);
    @(negedge clk);
    check("lat_edge_k1", {255'd0, out_valid}, 256'd1);
    wait_drain("drain_transpose");

    // Rounding and saturation corner values in row 5.
    fill_pat(7);
    for (int i = 0; i < 6; i++) begin
      in_m[5][i]  = rnd_in[i];
      exp_m[5][i] = rnd_exp[i];
    end
    send_rows(16);
    wait_drain("drain_round");

    // Four back-to-back blocks with no bubbles.
    stall_cnt = 0;
    base = pop_cyc_q.size();
    for (int b = 0; b < 4; b++) begin
      fill_pat(b);
      send_rows(16);
    end
    wait_drain("drain_stream");
    check("stream_stalls", 256'(stall_cnt), 256'd0);
    check("stream_cols", 256'(pop_cyc_q.size() - base), 256'd64);
    if (pop_cyc_q.size() - base >= 64)
      check("stream_gapless", 256'(pop_cyc_q[base+63] - pop_cyc_q[base]), 256'd63);

    // Back-pressure: 40 offered rows with the reader stalled.
    out_ready = 1'b0;
    acc_cnt   = 0;
    cur_blk   = -1;
    for (int i = 0; i < 40; i++) begin
      if (acc_cnt / 16 != cur_blk) begin
        cur_blk = acc_cnt / 16;
        fill_pat(10 + cur_blk);
      end
      in_row   = pack_row(acc_cnt % 16);
      in_valid = 1'b1;
      @(negedge clk);
      a = in_ready;
      @(posedge clk);
      #1;
      if (a) begin
        if (acc_cnt % 16 == 15) push_block();
        acc_cnt++;
      end
    end
    in_valid = 1'b0;
    check("bp_accepted", 256'(acc_cnt), 256'd32);
    @(negedge clk);
    check("bp_in_ready_low", {255'd0, in_ready}, 256'd0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    prev_rdy = in_ready;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (out_valid && out_last) begin
        seen = 1'b1;
        check("bp_rdy_before_free", {255'd0, prev_rdy}, 256'd0);
        check("bp_rdy_after_free", {255'd0, in_ready}, 256'd1);
      end
      prev_rdy = in_ready;
    end
    if (!seen) abort("bp_last");
    wait_drain("drain_bp");

    // Reset in the middle of a fill discards the partial block.
    fill_pat(20);
    send_rows(7);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    fill_pat(21);
    send_rows(16);
    wait_drain("drain_midfill");

    // Asynchronous reset while both banks are occupied and a column is held.
    out_ready = 1'b0;
    fill_pat(30);
    send_rows(16);
    fill_pat(31);
    send_rows(16);
    @(negedge clk);
    check("pre_rst_out_valid", {255'd0, out_valid}, 256'd1);
    check("pre_rst_in_ready", {255'd0, in_ready}, 256'd0);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", {255'd0, out_valid}, 256'd0);
    check("arst_in_ready", {255'd0, in_ready}, 256'd1);
    check("arst_out_col", out_col, 256'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("post_rst_idle", {255'd0, out_valid}, 256'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
